// File: rtl/seq_chunk_adder_pkg.sv
// +--------------------------------------------------------------------------+
// | adder_pkg                                                                |
// | Shared state encoding and sizing helpers for the sequential chunk adder. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package adder_pkg;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_BUSY = 1'b1;

    function automatic int num_chunks(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_chunk_adder_chunk.sv
// +--------------------------------------------------------------------------+
// | chunk_adder / full_adder                                                 |
// | CHUNK-bit ripple adder built from one-bit full-adder cells.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb
);
    logic [CHUNK:0] w_c;

    assign w_c[0] = i_cin;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            full_adder u_fa (
                .i_a  (i_a[gi]),
                .i_b  (i_b[gi]),
                .i_ci (w_c[gi]),
                .o_s  (o_sum[gi]),
                .o_co (w_c[gi+1])
            );
        end
    endgenerate

    // Carry into the top bit feeds signed-overflow detection in the caller.
    assign o_cout  = w_c[CHUNK];
    assign o_c_msb = w_c[CHUNK-1];
endmodule

`default_nettype wire

// File: rtl/seq_chunk_adder.sv
// +--------------------------------------------------------------------------+
// | seq_chunk_adder                                                          |
// | Multi-cycle add/subtract, CHUNK bits per clock, start/done handshake.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int              N      = num_chunks(WIDTH, CHUNK);
    localparam int              IDX_W  = idx_width(N);
    localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [IDX_W-1:0] r_idx;
    logic             r_done;
    logic             r_cout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;
    logic             w_chunk_cmsb;
    logic [WIDTH-1:0] w_acc_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start)  w_state_nxt = c_ST_BUSY;
            c_ST_BUSY: if (w_last) w_state_nxt = c_ST_IDLE;
            default:               w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        ready    = (r_state == c_ST_IDLE);
        w_accept = (r_state == c_ST_IDLE) && start;
        w_step   = (r_state == c_ST_BUSY);
        w_last   = (r_state == c_ST_BUSY) && (r_idx == c_LAST);
    end

    assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
    assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a     (w_a_chunk),
        .i_b     (w_b_chunk),
        .i_cin   (r_carry),
        .o_sum   (w_chunk_sum),
        .o_cout  (w_chunk_cout),
        .o_c_msb (w_chunk_cmsb)
    );

    // The completion edge publishes the accumulator including the chunk being written now.
    always_comb begin
        w_acc_nxt = r_acc;
        w_acc_nxt[r_idx*CHUNK +: CHUNK] = w_chunk_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= sub ? ~b : b;
                r_carry <= sub ? 1'b1 : cin;
                r_idx   <= '0;
            end else if (w_step) begin
                r_acc   <= w_acc_nxt;
                r_carry <= w_chunk_cout;
                if (w_last) begin
                    r_idx  <= '0;
                    r_sum  <= w_acc_nxt;
                    r_cout <= w_chunk_cout;
                    r_ovf  <= w_chunk_cmsb ^ w_chunk_cout;
                    r_done <= 1'b1;
                end else begin
                    r_idx  <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
// +--------------------------------------------------------------------------+
// | tb_seq_chunk_adder                                                       |
// | Directed checks of seq_chunk_adder at CHUNK = 8, 32 and 4 (WIDTH = 32).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seq_chunk_adder;
    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         start [3];
    logic         ready [3];
    logic         done  [3];
    logic         cout  [3];
    logic         ovf   [3];
    logic [W-1:0] sum   [3];
    logic [W-1:0] prev  [3];
    int           lat   [3] = '{4, 1, 8};
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(8)) u_n4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .sub(sub), .a(a), .b(b), .cin(cin),
        .ready(ready[0]), .done(done[0]), .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0])
    );
    seq_chunk_adder #(.WIDTH(W), .CHUNK(32)) u_n1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .sub(sub), .a(a), .b(b), .cin(cin),
        .ready(ready[1]), .done(done[1]), .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1])
    );
    seq_chunk_adder #(.WIDTH(W), .CHUNK(4)) u_n8 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .sub(sub), .a(a), .b(b), .cin(cin),
        .ready(ready[2]), .done(done[2]), .sum(sum[2]), .cout(cout[2]), .ovf(ovf[2])
    );

    task automatic chk(input string tag, input int k, input logic [W-1:0] obs, input logic [W-1:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s (N=%0d) observed=%0h expected=%0h", tag, lat[k], obs, expd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic s, input logic ci);
        a = av; b = bv; sub = s; cin = ci;
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
    endtask

    task automatic wait_done(input int k, output int cyc);
        cyc = 0;
        while (done[k] !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic run(input string tag, input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic s, input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
        int cyc;
        chk({tag, "_ready"}, k, ready[k], 1);
        issue(k, av, bv, s, ci);
        chk({tag, "_busy"}, k, ready[k], 0);
        chk({tag, "_hold"}, k, sum[k], prev[k]);
        wait_done(k, cyc);
        chk({tag, "_lat"},  k, cyc, lat[k]);
        chk({tag, "_sum"},  k, sum[k], es);
        chk({tag, "_cout"}, k, cout[k], ec);
        chk({tag, "_ovf"},  k, ovf[k], eo);
        prev[k] = es;
        tick();
        chk({tag, "_pulse"}, k, done[k], 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog (global time limit) observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        start = '{default: 1'b0};
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        rst_n = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", k, ready[k], 1);
            chk("rst_done",  k, done[k], 0);
            chk("rst_sum",   k, sum[k], 0);
            chk("rst_cout",  k, cout[k], 0);
            chk("rst_ovf",   k, ovf[k], 0);
            prev[k] = '0;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(k, cyc);
            chk("idle_nodone", k, cyc, 20);
        end

        for (int k = 0; k < 3; k++) begin
            run("inc_wrap", k, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            run("pos_ovf",  k, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
            run("sub_neg",  k, 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
            run("sub_pos",  k, 32'h7, 32'h5, 1'b1, 1'b0, 32'h2, 1'b1, 1'b0);

            // start pulsed while busy must be ignored
            issue(k, 32'h10, 32'h20, 1'b0, 1'b0);
            a = 32'h100; b = 32'h100; sub = 1'b0; cin = 1'b1;
            start[k] = 1'b1;
            tick();
            start[k] = 1'b0;
            wait_done(k, cyc);
            chk("ign_lat", k, cyc, lat[k] - 1);
            chk("ign_sum", k, sum[k], 32'h30);
            chk("ign_ready_in_done", k, ready[k], 1);

            // back-to-back start in the done cycle
            a = 32'h1; b = 32'h2; sub = 1'b0; cin = 1'b0;
            start[k] = 1'b1;
            tick();
            start[k] = 1'b0;
            chk("b2b_busy", k, ready[k], 0);
            chk("b2b_hold", k, sum[k], 32'h30);
            wait_done(k, cyc);
            chk("b2b_lat", k, cyc, lat[k]);
            chk("b2b_sum", k, sum[k], 32'h3);
            prev[k] = 32'h3;
            tick();

            // asynchronous reset in the middle of an operation
            issue(k, 32'hAAAA_0000, 32'h5555, 1'b0, 1'b0);
            repeat ((lat[k] > 2) ? 2 : (lat[k] - 1)) tick();
            #2;
            rst_n = 1'b0;
            #1;
            chk("mid_rst_ready", k, ready[k], 1);
            chk("mid_rst_done",  k, done[k], 0);
            chk("mid_rst_sum",   k, sum[k], 0);
            chk("mid_rst_cout",  k, cout[k], 0);
            chk("mid_rst_ovf",   k, ovf[k], 0);
            tick();
            rst_n = 1'b1;
            prev[k] = '0;
            wait_done(k, cyc);
            chk("mid_rst_nodone", k, cyc, 20);
            run("after_rst", k, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 32'h2345_678A, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
